// File: rtl/aes_if_pkg.sv
// Shared constants for the AES host interface: register map, bit positions
// inside CONFIG/START/STATUS, and key/block widths.
package aes_if_pkg;

    typedef enum logic [3:0] {
        ADDR_IDLE   = 4'd0,
        ADDR_CONFIG = 4'd1,
        ADDR_KEY    = 4'd2,
        ADDR_BLOCK  = 4'd3,
        ADDR_STATUS = 4'd5,
        ADDR_START  = 4'd6,
        ADDR_RESULT = 4'd7
    } addr_e;

    localparam int CFG_ENCDEC  = 0;
    localparam int CFG_KEYLEN  = 1;
    localparam int START_INIT  = 0;
    localparam int START_NEXT  = 1;
    localparam int ST_READY    = 0;
    localparam int ST_RESVALID = 1;
    localparam int ST_ERR      = 2;

    localparam int KEY_W128 = 128;
    localparam int KEY_W256 = 256;
    localparam int BLK_W    = 128;

    // Word counter width: enough for 256/8 = 32 words.
    localparam int CNT_W = 6;

endpackage

// File: rtl/aes_host_if_if.sv
// Host register bus: address select, write word and registered read word.
interface aes_host_if_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
);
    logic [3:0]       address;
    logic [IN_W-1:0]  data_in;
    logic [OUT_W-1:0] data_out;

    modport master (output address, output data_in, input  data_out);
    modport slave  (input  address, input  data_in, output data_out);
endinterface

// File: rtl/aes_word_loader.sv
// MSB-first shift register with a saturating word counter; full flags a
// complete uninterrupted load of max_i words.
module aes_word_loader
    import aes_if_pkg::*;
#(
    parameter int W    = 128,
    parameter int IN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [CNT_W-1:0] max_i,
    input  logic             clr_full_i,
    input  logic [IN_W-1:0]  data_i,
    output logic [W-1:0]     data_o,
    output logic             full_o
);
    logic [W-1:0]     sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             take;

    always_comb begin
        take   = en_i && (cnt_q < max_i);
        sr_d   = take ? {sr_q[W-IN_W-1:0], data_i} : sr_q;
        cnt_d  = !en_i ? '0 : (take ? cnt_q + CNT_W'(1) : cnt_q);
        full_d = full_q;
        // cnt_q is zero only on the first cycle of a (re-)entry
        if (en_i && cnt_q == '0) full_d = 1'b0;
        if (en_i && cnt_d == max_i) full_d = 1'b1;
        if (clr_full_i) full_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign data_o = sr_q;
    assign full_o = full_q;
endmodule

// File: rtl/aes_host_if.sv
// Register-mapped host front end for an AES core: key/block loading, start
// pulse generation with error flagging, and sliced result readback.
module aes_host_if
    import aes_if_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    aes_host_if_if.slave  host,
    output logic [255:0]  core_key,
    output logic [127:0]  core_block,
    output logic          core_encdec,
    output logic          core_keylen,
    output logic          core_init,
    output logic          core_next,
    input  logic          core_ready,
    input  logic          core_valid,
    input  logic [127:0]  core_result
);
    localparam int NS = BLK_W / OUT_W;
    localparam int PW = $clog2(NS);
    localparam logic [CNT_W-1:0] KW128 = CNT_W'(KEY_W128 / IN_W);
    localparam logic [CNT_W-1:0] KW256 = CNT_W'(KEY_W256 / IN_W);
    localparam logic [CNT_W-1:0] BW    = CNT_W'(BLK_W / IN_W);

    logic sel_cfg, sel_key, sel_blk, sel_status, sel_start, sel_result;
    logic encdec_q, encdec_d, keylen_q, keylen_d;
    logic err_q, err_d, res_valid_q, res_valid_d;
    logic init_prev_q, init_prev_d, next_prev_q, next_prev_d;
    logic cv_q, init_q, init_d, next_q, next_d;
    logic [127:0]     res_q, res_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [OUT_W-1:0] dout_q, dout_d;
    logic [255:0]     key_q;
    logic [127:0]     blk_q;
    logic             key_full, blk_full, keylen_chg;
    logic [CNT_W-1:0] kw;
    logic             init_rise, next_rise, err_evt, cv_rise;

    assign sel_cfg    = host.address == ADDR_CONFIG;
    assign sel_key    = host.address == ADDR_KEY;
    assign sel_blk    = host.address == ADDR_BLOCK;
    assign sel_status = host.address == ADDR_STATUS;
    assign sel_start  = host.address == ADDR_START;
    assign sel_result = host.address == ADDR_RESULT;

    assign kw         = keylen_q ? KW256 : KW128;
    assign keylen_chg = sel_cfg && (host.data_in[CFG_KEYLEN] != keylen_q);

    aes_word_loader #(.W(KEY_W256), .IN_W(IN_W)) u_key (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (sel_key),
        .max_i      (kw),
        .clr_full_i (keylen_chg),
        .data_i     (host.data_in),
        .data_o     (key_q),
        .full_o     (key_full)
    );

    aes_word_loader #(.W(BLK_W), .IN_W(IN_W)) u_blk (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (sel_blk),
        .max_i      (BW),
        .clr_full_i (1'b0),
        .data_i     (host.data_in),
        .data_o     (blk_q),
        .full_o     (blk_full)
    );

    // Start decode: init has priority; a simultaneous next rise is an error.
    always_comb begin
        init_rise = sel_start && host.data_in[START_INIT] && !init_prev_q;
        next_rise = sel_start && host.data_in[START_NEXT] && !next_prev_q;
        init_d    = init_rise && key_full;
        next_d    = !init_rise && next_rise && blk_full && core_ready;
        err_evt   = (init_rise && (!key_full || next_rise)) ||
                    (!init_rise && next_rise && !(blk_full && core_ready));
        cv_rise   = core_valid && !cv_q;
    end

    always_comb begin
        encdec_d    = sel_cfg ? host.data_in[CFG_ENCDEC] : encdec_q;
        keylen_d    = sel_cfg ? host.data_in[CFG_KEYLEN] : keylen_q;
        init_prev_d = sel_start ? host.data_in[START_INIT] : init_prev_q;
        next_prev_d = sel_start ? host.data_in[START_NEXT] : next_prev_q;
        res_d       = cv_rise ? core_result : res_q;
        res_valid_d = res_valid_q;
        if (init_d || next_d) res_valid_d = 1'b0;
        if (cv_rise) res_valid_d = 1'b1;
        err_d = sel_status ? 1'b0 : err_q;
        if (err_evt) err_d = 1'b1;
        ptr_d = sel_result ? ptr_q + PW'(1) : '0;
        dout_d = '0;
        case (host.address)
            ADDR_STATUS: dout_d = OUT_W'({err_q, res_valid_q, core_ready});
            ADDR_START:  dout_d = OUT_W'({keylen_q, encdec_q, 2'b00});
            ADDR_RESULT: dout_d = res_q[(NS-1-int'(ptr_q))*OUT_W +: OUT_W];
            default:     dout_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            encdec_q    <= 1'b0;
            keylen_q    <= 1'b0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            init_prev_q <= 1'b0;
            next_prev_q <= 1'b0;
            cv_q        <= 1'b0;
            init_q      <= 1'b0;
            next_q      <= 1'b0;
            res_q       <= '0;
            ptr_q       <= '0;
            dout_q      <= '0;
        end else begin
            encdec_q    <= encdec_d;
            keylen_q    <= keylen_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            init_prev_q <= init_prev_d;
            next_prev_q <= next_prev_d;
            cv_q        <= core_valid;
            init_q      <= init_d;
            next_q      <= next_d;
            res_q       <= res_d;
            ptr_q       <= ptr_d;
            dout_q      <= dout_d;
        end
    end

    // A 128-bit key sits in the low half of the shift register; present it MSB-aligned.
    assign core_key      = keylen_q ? key_q : {key_q[127:0], 128'h0};
    assign core_block    = blk_q;
    assign core_encdec   = encdec_q;
    assign core_keylen   = keylen_q;
    assign core_init     = init_q;
    assign core_next     = next_q;
    assign host.data_out = dout_q;
endmodule

// File: tb/tb_aes_host_if.sv
// Directed bench for aes_host_if at IN_W=16, OUT_W=8.
module tb_aes_host_if;
    import aes_if_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] core_key;
    logic [127:0] core_block;
    logic         core_encdec, core_keylen, core_init, core_next;
    logic         core_ready = 1'b0;
    logic         core_valid = 1'b0;
    logic [127:0] core_result = '0;
    int           tot = 0;
    int           bad = 0;
    int           n_init = 0;
    int           n_next = 0;

    aes_host_if_if #(.IN_W(16), .OUT_W(8)) hb ();

    aes_host_if #(.IN_W(16), .OUT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host        (hb),
        .core_key    (core_key),
        .core_block  (core_block),
        .core_encdec (core_encdec),
        .core_keylen (core_keylen),
        .core_init   (core_init),
        .core_next   (core_next),
        .core_ready  (core_ready),
        .core_valid  (core_valid),
        .core_result (core_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (core_init === 1'b1) n_init++;
        if (core_next === 1'b1) n_next++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [3:0] a, input logic [15:0] d);
        hb.address = a;
        hb.data_in = d;
        step();
    endtask

    task automatic test_reset();
        hb.address = 4'd0;
        hb.data_in = 16'h0;
        rst_n = 1'b0;
        step();
        tot++; if (hb.data_out !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h want=00", hb.data_out); end
        tot++; if ({core_init, core_next, core_keylen, core_encdec} !== 4'b0) begin bad++; $display("FAIL reset_ctl got=%b want=0000", {core_init, core_next, core_keylen, core_encdec}); end
        tot++; if (core_key !== 256'h0) begin bad++; $display("FAIL reset_key got=%h want=0", core_key); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 4; i++) begin
            bus(ADDR_IDLE, 16'habcd);
            tot++; if (hb.data_out !== 8'h00) begin bad++; $display("FAIL idle_dout[%0d] got=%h want=00", i, hb.data_out); end
        end
    endtask

    task automatic test_config_read();
        bus(ADDR_CONFIG, 16'h0003);
        bus(ADDR_START, 16'h0000);
        tot++; if (hb.data_out !== 8'b0000_1100) begin bad++; $display("FAIL start_read got=%h want=0c", hb.data_out); end
        tot++; if ({core_keylen, core_encdec} !== 2'b11) begin bad++; $display("FAIL cfg_bits got=%b want=11", {core_keylen, core_encdec}); end
        bus(4'd9, 16'hffff);
        tot++; if (hb.data_out !== 8'h00) begin bad++; $display("FAIL unmapped_dout got=%h want=00", hb.data_out); end
        tot++; if ({core_keylen, core_encdec} !== 2'b11) begin bad++; $display("FAIL unmapped_cfg got=%b want=11", {core_keylen, core_encdec}); end
    endtask

    task automatic test_key256();
        int n0;
        logic [255:0] exp_key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        for (int i = 0; i < 16; i++) bus(ADDR_KEY, 16'((2*i)*256 + 2*i + 1));
        bus(ADDR_START, 16'h0000);
        n0 = n_init;
        bus(ADDR_START, 16'h0001);
        tot++; if (core_init !== 1'b1) begin bad++; $display("FAIL init_pulse got=%b want=1", core_init); end
        bus(ADDR_START, 16'h0001);
        tot++; if (core_init !== 1'b0) begin bad++; $display("FAIL init_width got=%b want=0", core_init); end
        bus(ADDR_IDLE, 16'h0);
        tot++; if (n_init - n0 !== 1) begin bad++; $display("FAIL init_count got=%0d want=1", n_init - n0); end
        tot++; if (core_key !== exp_key) begin bad++; $display("FAIL key256 got=%h want=%h", core_key, exp_key); end
        // Partial (15-word) load must refuse init
        for (int i = 0; i < 15; i++) bus(ADDR_KEY, 16'((2*i)*256 + 2*i + 1));
        bus(ADDR_START, 16'h0000);
        n0 = n_init;
        bus(ADDR_START, 16'h0001);
        bus(ADDR_STATUS, 16'h0);
        tot++; if (hb.data_out !== 8'h04) begin bad++; $display("FAIL partial_err got=%h want=04", hb.data_out); end
        tot++; if (n_init !== n0) begin bad++; $display("FAIL partial_nopulse got=%0d want=%0d", n_init, n0); end
        bus(ADDR_STATUS, 16'h0);
        tot++; if (hb.data_out !== 8'h00) begin bad++; $display("FAIL err_clear got=%h want=00", hb.data_out); end
    endtask

    task automatic test_next();
        int n0;
        logic [127:0] blk = 128'h00112233445566778899aabbccddeeff;
        for (int i = 0; i < 8; i++) bus(ADDR_BLOCK, blk[127-16*i -: 16]);
        tot++; if (core_block !== blk) begin bad++; $display("FAIL block got=%h want=%h", core_block, blk); end
        core_ready = 1'b0;
        bus(ADDR_START, 16'h0000);
        n0 = n_next;
        bus(ADDR_START, 16'h0002);
        bus(ADDR_STATUS, 16'h0);
        tot++; if (hb.data_out !== 8'h04) begin bad++; $display("FAIL next_notready_err got=%h want=04", hb.data_out); end
        tot++; if (n_next !== n0) begin bad++; $display("FAIL next_notready_pulse got=%0d want=%0d", n_next, n0); end
        core_ready = 1'b1;
        bus(ADDR_START, 16'h0000);
        bus(ADDR_START, 16'h0002);
        tot++; if (core_next !== 1'b1) begin bad++; $display("FAIL next_pulse got=%b want=1", core_next); end
        bus(ADDR_STATUS, 16'h0);
        tot++; if (core_next !== 1'b0) begin bad++; $display("FAIL next_width got=%b want=0", core_next); end
        tot++; if (hb.data_out !== 8'h01) begin bad++; $display("FAIL next_status got=%h want=01", hb.data_out); end
    endtask

    task automatic test_result();
        logic [127:0] r = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        logic [7:0]   e;
        core_result = r;
        core_valid  = 1'b1;
        bus(ADDR_IDLE, 16'h0);
        core_valid  = 1'b0;
        core_result = '0;
        bus(ADDR_STATUS, 16'h0);
        tot++; if (hb.data_out !== 8'h03) begin bad++; $display("FAIL res_valid got=%h want=03", hb.data_out); end
        for (int i = 0; i < 17; i++) begin
            bus(ADDR_RESULT, 16'h0);
            e = r[127-8*(i%16) -: 8];
            tot++; if (hb.data_out !== e) begin bad++; $display("FAIL result[%0d] got=%h want=%h", i, hb.data_out, e); end
        end
        bus(ADDR_IDLE, 16'h0);
        bus(ADDR_RESULT, 16'h0);
        tot++; if (hb.data_out !== 8'h69) begin bad++; $display("FAIL result_restart got=%h want=69", hb.data_out); end
    endtask

    task automatic test_reset_midload();
        int n0;
        for (int i = 0; i < 5; i++) bus(ADDR_KEY, 16'h1234);
        rst_n = 1'b0;
        #2;
        tot++; if (core_key !== 256'h0 || hb.data_out !== 8'h00) begin bad++; $display("FAIL async_reset key=%h dout=%h want=0", core_key, hb.data_out); end
        rst_n = 1'b1;
        n0 = n_init;
        bus(ADDR_CONFIG, 16'h0002);
        for (int i = 0; i < 8; i++) bus(ADDR_KEY, 16'h1234);
        bus(ADDR_START, 16'h0000);
        bus(ADDR_START, 16'h0001);
        bus(ADDR_STATUS, 16'h0);
        tot++; if (hb.data_out !== 8'h05) begin bad++; $display("FAIL rst_partial_err got=%h want=05", hb.data_out); end
        tot++; if (n_init !== n0) begin bad++; $display("FAIL rst_nopulse got=%0d want=%0d", n_init, n0); end
    endtask

    task automatic test_key128();
        int n0;
        logic [127:0] k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        bus(ADDR_CONFIG, 16'h0000);
        for (int i = 0; i < 8; i++) bus(ADDR_KEY, k[127-16*i -: 16]);
        tot++; if (core_key !== {k, 128'h0}) begin bad++; $display("FAIL key128 got=%h want=%h", core_key, {k, 128'h0}); end
        core_result = 128'h1;
        core_valid  = 1'b1;
        bus(ADDR_START, 16'h0000);
        core_valid  = 1'b0;
        n0 = n_init;
        bus(ADDR_START, 16'h0003);
        tot++; if ({core_init, core_next} !== 2'b10) begin bad++; $display("FAIL both_rise got=%b want=10", {core_init, core_next}); end
        bus(ADDR_STATUS, 16'h0);
        tot++; if (hb.data_out !== 8'h05) begin bad++; $display("FAIL both_err_resclr got=%h want=05", hb.data_out); end
        bus(ADDR_CONFIG, 16'h0002);
        bus(ADDR_CONFIG, 16'h0000);
        bus(ADDR_START, 16'h0000);
        bus(ADDR_START, 16'h0001);
        bus(ADDR_STATUS, 16'h0);
        tot++; if (hb.data_out !== 8'h05) begin bad++; $display("FAIL keylen_chg_err got=%h want=05", hb.data_out); end
        tot++; if (n_init - n0 !== 1) begin bad++; $display("FAIL keylen_chg_pulses got=%0d want=1", n_init - n0); end
    endtask

    initial begin
        hb.address = 4'd0;
        hb.data_in = 16'h0;
        test_reset();
        test_idle();
        test_config_read();
        test_key256();
        test_next();
        test_result();
        test_reset_midload();
        test_key128();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule

// File: doc/aes_host_if.md
AES_HOST_IF -- requirements
Module: aes_host_if

Interface
REQ-001 SHALL have parameter IN_W, default 16, meaning host write-word width; legal values 8, 16, 32.
REQ-002 SHALL have parameter OUT_W, default 8, meaning host read-word width; legal values 8, 16, 32.
REQ-003 SHALL use one clock and an asynchronous active-low reset; all ports are listed below (name, direction, width, meaning).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 address  input  4  register select: 0 IDLE, 1 CONFIG, 2 KEY, 3 BLOCK, 5 STATUS, 6 START, 7 RESULT.
REQ-007 data_in  input  IN_W  host write data.
REQ-008 data_out  output  OUT_W  host read data, registered.
REQ-009 core_key  output  256  key to AES core; a 128-bit key occupies [255:128], and [127:0] is zero.
REQ-010 core_block  output  128  plaintext or ciphertext block to the core.
REQ-011 core_encdec, core_keylen  output  1 each  mode bits to the core.
REQ-012 core_init, core_next  output  1 each  single-cycle start pulses.
REQ-013 core_ready, core_valid  input  1 each  core status levels.
REQ-014 core_result  input  128  core output block.

Function
REQ-015 In every cycle with address==CONFIG, the block SHALL latch encdec=data_in[0] and keylen=data_in[1].
REQ-016 Each cycle with address==KEY, the block SHALL shift data_in into the key register MSB-first and increment key_cnt; key_cnt saturates at KW=(keylen?256:128)/IN_W, and words beyond KW are ignored.
REQ-017 BLOCK loading SHALL follow the same rule, with a 128-bit register, blk_cnt, and saturation at 128/IN_W.
REQ-018 key_cnt SHALL clear in any cycle where address!=KEY; blk_cnt SHALL clear in any cycle where address!=BLOCK. Each re-entry therefore restarts the load; a partial load leaves key_full/blk_full low.
REQ-019 key_full SHALL set when key_cnt reaches KW; it SHALL clear on re-entry to KEY and on any CONFIG write that changes keylen.
REQ-020 START decode: data_in[0] is init and data_in[1] is next; each is rising-edge detected against its value in the previous START cycle.
REQ-021 A core_init pulse of exactly 1 cycle SHALL issue only if key_full is set; otherwise the err bit SHALL set.
REQ-022 A core_next pulse of exactly 1 cycle SHALL issue only if blk_full and core_ready are set; otherwise err SHALL set.
REQ-023 If init and next rise in the same cycle, the block SHALL issue init only and set err.
REQ-024 On the rising edge of core_valid, the block SHALL capture core_result into res_reg and set res_valid.
REQ-025 res_valid SHALL clear on an accepted core_next or core_init.
REQ-026 data_out SHALL be registered, with one cycle of latency from address:
- IDLE/CONFIG/KEY/BLOCK: 0
- STATUS: {0, err, res_valid, core_ready}
- START: {0, keylen, encdec, 2'b00}
- RESULT: next OUT_W slice of res_reg, MSB-first
REQ-027 The RESULT read pointer SHALL clear whenever address!=RESULT, advance once per RESULT cycle, and wrap after 128/OUT_W slices.
REQ-028 A STATUS cycle SHALL clear err; if an error event occurs in the same cycle, set SHALL win.
REQ-029 Unmapped addresses (4, 8-15) SHALL produce data_out=0 and no state change.

Reset
REQ-030 Assertion of rst_n SHALL asynchronously clear all registers, counters, flags, pointers, data_out, core_init, and core_next to 0.
REQ-031 Reset mid-load or mid-encryption SHALL discard all partial state; no pulse SHALL be issued after deassertion.

Structure
REQ-032 Package aes_if_pkg SHALL hold the address constants, CONFIG/START/STATUS bit positions, and the 128/256 key-width constants.
REQ-033 The block SHALL use one sub-module, aes_word_loader (parametrised shift register plus saturating counter), instantiated for KEY and BLOCK.

Verification
REQ-034 Reset, then address=0 and data_in=16'habcd for 4 cycles -> data_out=0 throughout.
REQ-035 CONFIG with data_in=16'h0003, then START with data_in=0 -> data_out=8'b00001100 one cycle later.
REQ-036 keylen=1, IN_W=16: load 16 words 000102..1f via KEY, then START init rise -> one core_init pulse and core_key=000102..1f. The same sequence with 15 words -> no pulse and STATUS err=1.
REQ-037 Load 8 block words, then raise START next with core_ready=0 -> err set and no pulse. Repeat with core_ready=1 -> one core_next pulse.
REQ-038 Pulse core_valid with core_result=69c4e0d8..c55a; read RESULT 16 cycles at OUT_W=8 -> bytes 69,c4,..,5a in order; a 17th cycle -> 69 (wrap).
REQ-039 Assert rst_n low during a KEY load, then complete only 8 words after reset -> key_full=0 and START init sets err.
